jk_cmd_sequencer: RTL
=====================

JK_CMD_SEQUENCER -- requirements
Module: jk_cmd_sequencer

Interface
REQ-001 Parameter DEPTH, default 4: command FIFO depth, power of two, at least 2.
REQ-002 Parameter CNT_W, default 4: width of the per-command repeat length.
REQ-003 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 Port rst, input, 1: reset, synchronous and active-high.
REQ-005 Port cmd_valid, input, 1: upstream presents a command.
REQ-006 Port cmd_ready, output, 1: sequencer can accept a command this cycle.
REQ-007 Port cmd_op, input, 2: JK operation; 00 hold, 01 clear, 10 set, 11 toggle.
REQ-008 Port cmd_len, input, CNT_W: number of consecutive cycles to apply cmd_op; 0 is treated as 1.
REQ-009 Port j, output, 1: registered J drive to the downstream JK flip-flop stage.
REQ-010 Port k, output, 1: registered K drive to the downstream JK flip-flop stage.
REQ-011 Port busy, output, 1: high while a command is being issued or the FIFO is non-empty.
REQ-012 Port done, output, 1: one-cycle pulse on the last issue cycle of each command.
REQ-013 Port q_model, output, 1: predicted downstream q, cycle-exact with a JK stage sharing clk/rst and driven by j/k.

Function
REQ-014 Handshake: a command is accepted on a rising edge where cmd_valid && cmd_ready; cmd_ready = !full && !rst; there is no pass-through when full.
REQ-015 A command accepted while the FIFO is full is impossible by construction; cmd_valid with cmd_ready=0 shall leave all state unchanged.
REQ-016 Push and pop on the same edge shall both take effect, and the occupancy shall stay unchanged.
REQ-017 FSM states: IDLE, ISSUE.
REQ-018 IDLE with the FIFO non-empty: pop the head, load op, load cnt = max(len,1), go to ISSUE.
REQ-019 ISSUE: {j,k} = op, registered, and cnt decrements each cycle.
REQ-020 ISSUE with cnt==1 and the FIFO non-empty: pop the next command on the same edge, with no bubble cycle between commands.
REQ-021 ISSUE with cnt==1 and the FIFO empty: go to IDLE.
REQ-022 In IDLE, j=0 and k=0, which is the hold operation.
REQ-023 Latency: a command accepted at edge N drives j/k from edge N+1 when the FIFO and FSM are idle.
REQ-024 done shall be high exactly during the final issue cycle of each command, aligned with its j/k.
REQ-025 q_model shall update at each edge from the current j/k: 00 hold, 01 becomes 0, 10 becomes 1, 11 inverts.
REQ-026 The FIFO read and write pointers shall be log2(DEPTH)+1 bits wide and wrap modulo 2*DEPTH; full/empty shall be decoded from the MSB difference.

Reset
REQ-027 While rst is high at an edge: FSM goes to IDLE, the FIFO is flushed, cnt=0, j=0, k=0, done=0, q_model=0.
REQ-028 While rst is high: cmd_ready=0, and busy=0 after the edge.
REQ-029 A reset asserted in the middle of a command shall abort that command with no done pulse, and the remaining FIFO contents shall be discarded.

Structure
REQ-030 A shared package jk_pkg shall hold the op encodings (JK_HOLD, JK_CLR, JK_SET, JK_TGL) and the FSM state typedef.
REQ-031 The FIFO shall be a separate sub-module, jk_cmd_fifo, parameterised by DEPTH and by an entry width of 2+CNT_W bits.
REQ-032 The FSM, counter and q_model shall reside in jk_cmd_sequencer.

Verification
REQ-033 Reset with FSM idle: push SET len=3 -> j=1,k=0 for exactly 3 cycles starting 1 edge after acceptance; done on the 3rd cycle; q_model=1 after the first edge.
REQ-034 Back-to-back: push TGL len=4 then CLR len=0 -> {j,k}=11 for 4 cycles then 01 for 1 cycle with no gap; q_model sequence 1,0,1,0,0; two done pulses.
REQ-035 Full: with DEPTH=4 and the FSM stalled on TGL len=15, push 4 commands -> cmd_ready=0 after the 4th; a 5th cmd_valid is ignored; all 4 issue in order afterwards.
REQ-036 Simultaneous push/pop at cnt==1 with the FIFO holding 1 entry -> occupancy stays 1 and the next op starts on the following cycle.
REQ-037 Reset mid-command: assert rst in the 2nd cycle of SET len=5 with 2 queued entries -> next cycle j=k=0, q_model=0, busy=0, no done pulse, and the queued entries never issue.
REQ-038 Scoreboard: a jk_flipflop instance driven by j/k on the same clk/rst shall give q == q_model on every cycle under random traffic of at least 10k cycles.

Source files
------------

// File: rtl/jk_pkg.sv
// Shared definitions for the JK command sequencer: op encodings, FSM state, next-q helper.
package jk_pkg;

   localparam logic [1:0] JK_HOLD = 2'b00;
   localparam logic [1:0] JK_CLR  = 2'b01;
   localparam logic [1:0] JK_SET  = 2'b10;
   localparam logic [1:0] JK_TGL  = 2'b11;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_ISSUE = 1'b1
   } jk_state_e;

   function automatic logic jk_next(input logic q, input logic [1:0] jk);
      logic nq;
      case (jk)
         JK_CLR:  nq = 1'b0;
         JK_SET:  nq = 1'b1;
         JK_TGL:  nq = ~q;
         default: nq = q;
      endcase
      return nq;
   endfunction

endpackage

// File: rtl/jk_cmd_fifo.sv
// Command FIFO with (log2(DEPTH)+1)-bit pointers; full/empty come from the MSB difference.
module jk_cmd_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 6
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push_i,
   input  logic [W-1:0] wdata_i,
   input  logic         pop_i,
   output logic [W-1:0] rdata_o,
   output logic         full_o,
   output logic         empty_o
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]  wptr_q, rptr_q;
   logic [AW:0]  wptr_d, rptr_d;
   logic [W-1:0] mem_q [DEPTH];
   logic         push_ok, pop_ok;

   assign empty_o = (wptr_q == rptr_q);
   assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
   assign rdata_o = mem_q[rptr_q[AW-1:0]];

   // Overflow/underflow requests are dropped here so callers can stay simple.
   assign push_ok = push_i && !full_o;
   assign pop_ok  = pop_i && !empty_o;

   always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      if (push_ok) wptr_d = wptr_q + (AW+1)'(1);
      if (pop_ok)  rptr_d = rptr_q + (AW+1)'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wptr_q[AW-1:0]] <= wdata_i;
   end

endmodule

// File: rtl/jk_cmd_sequencer.sv
// Queues JK commands and replays each op on registered j/k for len cycles,
// predicting the downstream JK flop output in q_model.
module jk_cmd_sequencer
   import jk_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic [CNT_W-1:0] cmd_len,
   output logic             j,
   output logic             k,
   output logic             busy,
   output logic             done,
   output logic             q_model,
   output jk_state_e        state_dbg
);

   localparam int EW = 2 + CNT_W;

   jk_state_e        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             j_q, j_d, k_q, k_d, q_q;

   logic             fifo_full, fifo_empty, fifo_pop, fifo_push;
   logic [EW-1:0]    fifo_rdata;
   logic [1:0]       head_op;
   logic [CNT_W-1:0] head_len, head_cnt;

   // Handshake: a command transfers on a rising edge with cmd_valid && cmd_ready;
   // cmd_ready depends only on FIFO fullness and rst, never on cmd_valid.
   assign cmd_ready = !fifo_full && !rst;
   assign fifo_push = cmd_valid && cmd_ready;

   jk_cmd_fifo #(.DEPTH(DEPTH), .W(EW)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (fifo_push),
      .wdata_i ({cmd_op, cmd_len}),
      .pop_i   (fifo_pop),
      .rdata_o (fifo_rdata),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   assign head_op  = fifo_rdata[EW-1 -: 2];
   assign head_len = fifo_rdata[CNT_W-1:0];
   assign head_cnt = (head_len == '0) ? CNT_W'(1) : head_len;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      j_d      = j_q;
      k_d      = k_q;
      fifo_pop = 1'b0;
      case (state_q)
         ST_IDLE: begin
            j_d = 1'b0;
            k_d = 1'b0;
            if (!fifo_empty) begin
               fifo_pop   = 1'b1;
               {j_d, k_d} = head_op;
               cnt_d      = head_cnt;
               state_d    = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (cnt_q == CNT_W'(1)) begin
               // Chain straight into the next command so there is no bubble cycle.
               if (!fifo_empty) begin
                  fifo_pop   = 1'b1;
                  {j_d, k_d} = head_op;
                  cnt_d      = head_cnt;
               end else begin
                  j_d     = 1'b0;
                  k_d     = 1'b0;
                  cnt_d   = '0;
                  state_d = ST_IDLE;
               end
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         j_q     <= 1'b0;
         k_q     <= 1'b0;
         q_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         j_q     <= j_d;
         k_q     <= k_d;
         q_q     <= jk_next(q_q, {j_q, k_q});
      end
   end

   assign j         = j_q;
   assign k         = k_q;
   assign q_model   = q_q;
   assign done      = (state_q == ST_ISSUE) && (cnt_q == CNT_W'(1));
   assign busy      = (state_q == ST_ISSUE) || !fifo_empty;
   assign state_dbg = state_q;

endmodule
